// File: rtl/gray_to_binary_pipe.sv
// ---------------------------------------------------------------------------
// gray_to_binary_pipe
//
// Two-stage pipelined Gray-to-binary decoder with valid/ready handshakes on
// both sides. It is the receive-side counterpart of binary_to_gray and
// recovers binary counts from Gray-coded pointers or position codes.
//
// Stage S1 registers the incoming Gray word. Stage S2 registers the decoded
// binary word together with its sequence-error flag.
//
// Optional feature macro: GRAY_TO_BINARY_SEQ_CHECK_EN
//   defined   - the sequence checker is built. It verifies that each decoded
//               word is the previous word + 1 (mod 2^len) and keeps a
//               saturating 8-bit count of violations.
//   undefined - the checker is removed, and seq_err and err_count are tied
//               to 0. Decode, handshake and latency are unchanged.
//
// Parameters
//   len        code width in bits, legal range 2..16
//
// Ports
//   clk        clock; all state updates occur on its rising edge
//   rst        synchronous active-high reset; has priority over transfers
//   in         Gray-coded input word
//   in_valid   in is valid this cycle
//   in_ready   block accepts in this cycle (combinational from out_ready)
//   out        decoded binary word
//   out_valid  out and seq_err are valid this cycle
//   out_ready  downstream accepts out this cycle
//   seq_err    word on out broke the +1 sequence (qualified by out_valid)
//   err_count  saturating count of sequence errors since reset
// ---------------------------------------------------------------------------
module gray_to_binary_pipe #(
  parameter int len = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [len-1:0] in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [len-1:0] out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           seq_err,
  output logic [7:0]     err_count
);

  logic [len-1:0] s1_q;
  logic           s1_valid_q;
  logic [len-1:0] out_q;
  logic           out_valid_q;
  logic [len-1:0] bin;
  logic           s2_load;
  logic           s1_load;
  logic           move;

  // S2 is free when it is empty or is being drained this cycle. S1 is free
  // when it is empty or is handing its word to S2. in_ready therefore
  // depends only on registered state and out_ready, never on in_valid.
  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign move     = s1_valid_q && s2_load;

  // Each binary bit b[i] is the XOR of all Gray bits from i upward. This is
  // the closed form of the prefix b[i] = b[i+1] ^ g[i]. Writing every bit
  // directly avoids a self-referencing vector.
  for (genvar gi = 0; gi < len; gi++) begin : g_decode
    assign bin[gi] = ^s1_q[len-1:gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_q <= in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_q <= bin;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef GRAY_TO_BINARY_SEQ_CHECK_EN
  typedef enum logic {
    NO_REF = 1'b0,
    TRACK  = 1'b1
  } chk_state_t;

  chk_state_t     state_q;
  chk_state_t     state_d;
  logic [len-1:0] prev_q;
  logic [len-1:0] prev_inc;
  logic           seq_err_q;
  logic           seq_err_d;
  logic [7:0]     err_count_q;

  // The addition is truncated to len bits, so an all-ones prev followed by
  // 0 counts as a legal wrap.
  assign prev_inc = prev_q + {{(len-1){1'b0}}, 1'b1};

  // State register. The checker advances only when a word moves S1 -> S2.
  // prev follows every moved word, including erroneous ones, so a single
  // jump is reported once and the checker then resynchronises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= NO_REF;
      prev_q      <= '0;
      seq_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (move) begin
        prev_q    <= bin;
        seq_err_q <= seq_err_d;
        if (seq_err_d && (err_count_q != 8'hFF)) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end
    end
  end

  // Next-state logic. The first moved word provides the reference.
  always_comb begin
    state_d = state_q;
    if (move) begin
      state_d = TRACK;
    end
  end

  // Output logic. No reference exists yet in NO_REF, so the word is
  // unchecked.
  always_comb begin
    seq_err_d = 1'b0;
    if (state_q == TRACK) begin
      seq_err_d = (bin != prev_inc);
    end
  end

  assign seq_err   = seq_err_q;
  assign err_count = err_count_q;
`else
  assign seq_err   = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_gray_to_binary_pipe.sv
// ---------------------------------------------------------------------------
// tb_gray_to_binary_pipe
//
// Directed self-checking bench for gray_to_binary_pipe with len = 4.
// Inputs are driven on the falling edge, and outputs are sampled 1 ns later,
// well away from the rising edge. The expected values are hand-computed from
// the Gray table below. Sequence-checker expectations depend on whether
// GRAY_TO_BINARY_SEQ_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_gray_to_binary_pipe;

  localparam int LEN = 4;

`ifdef GRAY_TO_BINARY_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [LEN-1:0] tb_in = '0;
  logic           tb_in_valid = 1'b0;
  logic           tb_in_ready;
  logic [LEN-1:0] tb_out;
  logic           tb_out_valid;
  logic           tb_out_ready = 1'b0;
  logic           tb_seq_err;
  logic [7:0]     tb_err_count;

  int errors = 0;
  int checks = 0;

  // Gray code of binary 0..15, written out by hand.
  logic [3:0] gray_tbl [0:15] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  always #5 clk = ~clk;

  gray_to_binary_pipe #(.len(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (tb_in),
    .in_valid  (tb_in_valid),
    .in_ready  (tb_in_ready),
    .out       (tb_out),
    .out_valid (tb_out_valid),
    .out_ready (tb_out_ready),
    .seq_err   (tb_seq_err),
    .err_count (tb_err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [LEN-1:0] word, input logic ordy);
    @(negedge clk);
    tb_in_valid  = v;
    tb_in        = word;
    tb_out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  logic [3:0] seq_b [0:3] = '{4'd3, 4'd4, 4'd9, 4'd10};
  logic       seq_e [0:3] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    // Reset state.
    do_reset();
    chk("rst_in_ready", 32'(tb_in_ready), 32'd1);
    chk("rst_out_valid", 32'(tb_out_valid), 32'd0);
    chk("rst_out", 32'(tb_out), 32'd0);
    chk("rst_seq_err", 32'(tb_seq_err), 32'd0);
    chk("rst_err_count", 32'(tb_err_count), 32'd0);

    // Full-rate sweep 0..15 then 0 again, with a 2-cycle latency.
    for (int k = 0; k < 19; k++) begin
      drive(k < 17, gray_tbl[k % 16], 1'b1);
      if (k >= 2) begin
        chk($sformatf("sweep_valid_%0d", k), 32'(tb_out_valid), 32'd1);
        chk($sformatf("sweep_out_%0d", k), 32'(tb_out), 32'((k - 2) % 16));
        chk($sformatf("sweep_err_%0d", k), 32'(tb_seq_err), 32'd0);
      end else begin
        chk($sformatf("sweep_lat_%0d", k), 32'(tb_out_valid), 32'd0);
      end
      $display("sweep step %0d: out_valid=%0d out=%0d", k, tb_out_valid, tb_out);
    end
    chk("sweep_err_count", 32'(tb_err_count), 32'd0);

    // Backpressure: offer binary 3, 4, 5 while out_ready is low.
    do_reset();
    drive(1'b1, gray_tbl[3], 1'b0);
    chk("bp_acc0", 32'(tb_in_ready), 32'd1);
    drive(1'b1, gray_tbl[4], 1'b0);
    chk("bp_acc1", 32'(tb_in_ready), 32'd1);
    drive(1'b1, gray_tbl[5], 1'b0);
    chk("bp_full_ready", 32'(tb_in_ready), 32'd0);
    chk("bp_full_valid", 32'(tb_out_valid), 32'd1);
    chk("bp_hold_a", 32'(tb_out), 32'd3);
    drive(1'b1, gray_tbl[5], 1'b0);
    chk("bp_hold_b", 32'(tb_out), 32'd3);
    chk("bp_still_full", 32'(tb_in_ready), 32'd0);
    drive(1'b1, gray_tbl[5], 1'b1);
    chk("bp_drain_ready", 32'(tb_in_ready), 32'd1);
    chk("bp_out0", 32'(tb_out), 32'd3);
    drive(1'b0, '0, 1'b1);
    chk("bp_out1_v", 32'(tb_out_valid), 32'd1);
    chk("bp_out1", 32'(tb_out), 32'd4);
    drive(1'b0, '0, 1'b1);
    chk("bp_out2_v", 32'(tb_out_valid), 32'd1);
    chk("bp_out2", 32'(tb_out), 32'd5);
    chk("bp_out2_err", 32'(tb_seq_err), 32'd0);
    drive(1'b0, '0, 1'b1);
    chk("bp_empty", 32'(tb_out_valid), 32'd0);
    $display("backpressure: delivered 3,4,5");

    // Sequence error: binary 3, 4, 9, 10.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(k < 4, gray_tbl[seq_b[k % 4]], 1'b1);
      if (k >= 2) begin
        chk($sformatf("seq_valid_%0d", k), 32'(tb_out_valid), 32'd1);
        chk($sformatf("seq_out_%0d", k), 32'(tb_out), 32'(seq_b[k - 2]));
        chk($sformatf("seq_err_%0d", k), 32'(tb_seq_err), 32'(seq_e[k - 2] & SEQ_EN));
        $display("seq step %0d: out=%0d seq_err=%0d err_count=%0d",
                 k, tb_out, tb_seq_err, tb_err_count);
      end
    end
    chk("seq_err_count", 32'(tb_err_count), SEQ_EN ? 32'd1 : 32'd0);

`ifdef GRAY_TO_BINARY_SEQ_CHECK_EN
    // Saturation: 300 words alternating 0, 5 give 299 errors, saturating at 255.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, (i % 2 == 1) ? gray_tbl[5] : gray_tbl[0], 1'b1);
    end
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("sat_err_count", 32'(tb_err_count), 32'd255);
    $display("saturation: err_count=%0d", tb_err_count);
`endif

    // Reset mid-stream with both stages full (binary 12, 13).
    do_reset();
    drive(1'b1, gray_tbl[12], 1'b0);
    drive(1'b1, gray_tbl[13], 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("mid_full", 32'(tb_in_ready), 32'd0);
    chk("mid_full_valid", 32'(tb_out_valid), 32'd1);
    @(negedge clk);
    rst          = 1'b1;
    tb_in_valid  = 1'b1;
    tb_in        = gray_tbl[9];
    tb_out_ready = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    tb_in_valid = 1'b0;
    #1;
    chk("mid_out_valid", 32'(tb_out_valid), 32'd0);
    chk("mid_in_ready", 32'(tb_in_ready), 32'd1);
    drive(1'b1, gray_tbl[7], 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("mid_next_valid", 32'(tb_out_valid), 32'd1);
    chk("mid_next_out", 32'(tb_out), 32'd7);
    chk("mid_next_err", 32'(tb_seq_err), 32'd0);
    chk("mid_err_count", 32'(tb_err_count), 32'd0);
    $display("reset mid-stream: next out=%0d seq_err=%0d", tb_out, tb_seq_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
